// File: rtl/apb_splitter_tmo.sv
// APB fan-out stage with watchdog timeout.
// Decodes the upstream APB bus into per-slave selects and muxes the selected
// slave's return path. A slave that holds PREADY low for TIMEOUT access cycles
// is cut off with a forced error completion, and the failure is recorded.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no mapped transfer in flight; setup phases are decoded here
// ACCESS | access phase to slot sel, counting wait cycles in cnt
// TMO    | one forced error completion cycle; slave selects suppressed
module apb_splitter_tmo #(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB    = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       PCLKEN,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic [31:0]                PADDR,
  output logic [31:0]                PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic [NUM_SLAVES-1:0]      PSELx,
  input  logic [NUM_SLAVES-1:0]      PREADYx,
  input  logic [NUM_SLAVES-1:0]      PSLVERRx,
  input  logic [32*NUM_SLAVES-1:0]   PRDATAx,
  input  logic                       TMO_CLR,
  output logic                       TMO_FLAG,
  output logic [31:0]                TMO_ADDR
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_TMO} state_t;

  // Last wait count before the watchdog fires; unused when TIMEOUT is 0.
  localparam logic [15:0] CNT_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [3:0]  sel, sel_nxt;
  logic [3:0]  idx;
  logic        mapped;
  logic        tmo_set;
  logic        ready_sel, err_sel;
  logic [31:0] rdata_sel;

  assign idx    = PADDR[SEL_LSB+3:SEL_LSB];
  assign mapped = ({1'b0, idx} < 5'(NUM_SLAVES));

  // Combinational slave selects so they are already valid in the setup phase.
  always_comb begin
    PSELx = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      PSELx[i] = PSEL && mapped && (state != ST_TMO) && (idx == 4'(i));
    end
  end

  // Pick the return-path signals of the latched slot.
  always_comb begin
    ready_sel = 1'b0;
    err_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == 4'(i)) begin
        ready_sel = PREADYx[i];
        err_sel   = PSLVERRx[i];
        rdata_sel = PRDATAx[32*i +: 32];
      end
    end
  end

  // Next-state, wait counter and upstream return path.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel;
    tmo_set   = 1'b0;
    PREADY    = 1'b1;
    PSLVERR   = 1'b0;
    PRDATA    = '0;
    case (state)
      ST_IDLE: begin
        if (PSEL && !mapped) begin
          PSLVERR = 1'b1;
        end
        if (PSEL && !PENABLE && mapped) begin
          state_nxt = ST_ACCESS;
          cnt_nxt   = '0;
          sel_nxt   = idx;
        end
      end
      ST_ACCESS: begin
        PREADY  = ready_sel;
        PSLVERR = err_sel;
        PRDATA  = rdata_sel;
        if (ready_sel) begin
          state_nxt = ST_IDLE;
        end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          state_nxt = ST_TMO;
          tmo_set   = 1'b1;
        end else if (cnt != 16'hFFFF) begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ST_TMO: begin
        PSLVERR   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; advances only on APB-enabled edges.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sel   <= '0;
    end else if (PCLKEN) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sel   <= sel_nxt;
    end
  end

  // Sticky timeout flag and address capture; a new timeout beats a clear.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      TMO_FLAG <= 1'b0;
      TMO_ADDR <= '0;
    end else if (PCLKEN && tmo_set) begin
      TMO_FLAG <= 1'b1;
      TMO_ADDR <= PADDR;
    end else if (TMO_CLR) begin
      TMO_FLAG <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_splitter_tmo.sv
// Directed testbench for apb_splitter_tmo (NUM_SLAVES=4, SEL_LSB=8, TIMEOUT=4).
module tb_apb_splitter_tmo;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic         PCLKEN;
  logic         PSEL, PENABLE;
  logic [31:0]  PADDR;
  logic [31:0]  PRDATA;
  logic         PREADY, PSLVERR;
  logic [3:0]   PSELx;
  logic [3:0]   PREADYx, PSLVERRx;
  logic [127:0] PRDATAx;
  logic         TMO_CLR;
  logic         TMO_FLAG;
  logic [31:0]  TMO_ADDR;

  int n_chk  = 0;
  int n_fail = 0;

  apb_splitter_tmo #(.NUM_SLAVES(4), .SEL_LSB(8), .TIMEOUT(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PCLKEN(PCLKEN), .PSEL(PSEL), .PENABLE(PENABLE),
    .PADDR(PADDR), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .PSELx(PSELx),
    .PREADYx(PREADYx), .PSLVERRx(PSLVERRx), .PRDATAx(PRDATAx), .TMO_CLR(TMO_CLR),
    .TMO_FLAG(TMO_FLAG), .TMO_ADDR(TMO_ADDR)
  );

  always #5 HCLK = ~HCLK;

  // Returns 2 time units after a rising edge; inputs change here.
  task automatic tick;
    @(posedge HCLK);
    #2;
  endtask

  // Three HCLK edges of which only the last is PCLKEN-qualified.
  task automatic pclk_cycle;
    tick;
    tick;
    PCLKEN = 1'b1;
    tick;
    PCLKEN = 1'b0;
  endtask

  task automatic test_reset;
    HRESETn = 1'b0; PCLKEN = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PADDR = '0;
    PREADYx = 4'b1111; PSLVERRx = 4'b0000; TMO_CLR = 1'b0;
    PRDATAx = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    #1;
    n_chk++; if ({PSELx, PREADY, PSLVERR, PRDATA} !== {4'b0000, 1'b1, 1'b0, 32'h0}) begin n_fail++;
      $display("FAIL reset_outputs: psel=%b rdy=%b err=%b rdata=%h exp psel=0000 rdy=1 err=0 rdata=0", PSELx, PREADY, PSLVERR, PRDATA); end
    n_chk++; if ({TMO_FLAG, TMO_ADDR} !== 33'h0) begin n_fail++;
      $display("FAIL reset_tmo: flag=%b addr=%h exp 0/0", TMO_FLAG, TMO_ADDR); end
    tick;
    HRESETn = 1'b1;
    tick;
  endtask

  task automatic test_read_slot2;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h200;
    #1;
    n_chk++; if (PSELx !== 4'b0100) begin n_fail++;
      $display("FAIL rd2_setup_psel: got %b exp 0100", PSELx); end
    tick;
    PENABLE = 1'b1;
    #1;
    n_chk++; if ({PSELx, PREADY, PSLVERR, PRDATA} !== {4'b0100, 1'b1, 1'b0, 32'hA5A5_0002}) begin n_fail++;
      $display("FAIL rd2_access: psel=%b rdy=%b err=%b rdata=%h exp 0100/1/0/a5a50002", PSELx, PREADY, PSLVERR, PRDATA); end
    tick;
    PSEL = 1'b0; PENABLE = 1'b0;
    #1;
    n_chk++; if ({PSELx, PREADY, PSLVERR} !== {4'b0000, 1'b1, 1'b0}) begin n_fail++;
      $display("FAIL rd2_idle: psel=%b rdy=%b err=%b exp 0000/1/0", PSELx, PREADY, PSLVERR); end
  endtask

  // Ready arrives at cnt == TIMEOUT-1: ready must win over the watchdog.
  task automatic test_wait_slot1;
    PREADYx[1] = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h100;
    tick;
    PENABLE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++; if ({PSELx, PREADY} !== {4'b0010, 1'b0}) begin n_fail++;
        $display("FAIL wr1_wait%0d: psel=%b rdy=%b exp 0010/0", k, PSELx, PREADY); end
      tick;
    end
    PREADYx[1] = 1'b1;
    #1;
    n_chk++; if ({PSELx, PREADY, PSLVERR, PRDATA} !== {4'b0010, 1'b1, 1'b0, 32'hA5A5_0001}) begin n_fail++;
      $display("FAIL wr1_done: psel=%b rdy=%b err=%b rdata=%h exp 0010/1/0/a5a50001", PSELx, PREADY, PSLVERR, PRDATA); end
    tick;
    PSEL = 1'b0; PENABLE = 1'b0;
    #1;
    n_chk++; if ({TMO_FLAG, PREADY, PSLVERR} !== {1'b0, 1'b1, 1'b0}) begin n_fail++;
      $display("FAIL wr1_no_tmo: flag=%b rdy=%b err=%b exp 0/1/0", TMO_FLAG, PREADY, PSLVERR); end
  endtask

  task automatic test_timeout;
    PREADYx[0] = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h10;
    tick;
    PENABLE = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_chk++; if ({PSELx, PREADY, PSLVERR} !== {4'b0001, 1'b0, 1'b0}) begin n_fail++;
        $display("FAIL tmo_wait%0d: psel=%b rdy=%b err=%b exp 0001/0/0", k, PSELx, PREADY, PSLVERR); end
      tick;
    end
    #1;
    n_chk++; if ({PSELx, PREADY, PSLVERR, PRDATA} !== {4'b0000, 1'b1, 1'b1, 32'h0}) begin n_fail++;
      $display("FAIL tmo_err_cycle: psel=%b rdy=%b err=%b rdata=%h exp 0000/1/1/0", PSELx, PREADY, PSLVERR, PRDATA); end
    n_chk++; if ({TMO_FLAG, TMO_ADDR} !== {1'b1, 32'h10}) begin n_fail++;
      $display("FAIL tmo_capture: flag=%b addr=%h exp 1/00000010", TMO_FLAG, TMO_ADDR); end
    tick;
    PSEL = 1'b0; PENABLE = 1'b0;
    #1;
    n_chk++; if ({TMO_FLAG, PSLVERR} !== {1'b1, 1'b0}) begin n_fail++;
      $display("FAIL tmo_sticky: flag=%b err=%b exp 1/0", TMO_FLAG, PSLVERR); end
    TMO_CLR = 1'b1;
    tick;
    TMO_CLR = 1'b0;
    #1;
    n_chk++; if (TMO_FLAG !== 1'b0) begin n_fail++;
      $display("FAIL tmo_clear: flag=%b exp 0", TMO_FLAG); end
    // Second hang with TMO_CLR held: the set on the timeout edge must win.
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h20; TMO_CLR = 1'b1;
    tick;
    PENABLE = 1'b1;
    for (int k = 0; k < 4; k++) tick;
    #1;
    n_chk++; if ({TMO_FLAG, TMO_ADDR, PSLVERR} !== {1'b1, 32'h20, 1'b1}) begin n_fail++;
      $display("FAIL tmo_set_wins: flag=%b addr=%h err=%b exp 1/00000020/1", TMO_FLAG, TMO_ADDR, PSLVERR); end
    tick;
    PSEL = 1'b0; PENABLE = 1'b0;
    #1;
    n_chk++; if (TMO_FLAG !== 1'b0) begin n_fail++;
      $display("FAIL tmo_clr_after_set: flag=%b exp 0", TMO_FLAG); end
    TMO_CLR = 1'b0;
    PREADYx[0] = 1'b1;
    tick;
  endtask

  task automatic test_unmapped;
    logic [31:0] addrs [2];
    addrs[0] = 32'h400;
    addrs[1] = 32'hF00;
    for (int a = 0; a < 2; a++) begin
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = addrs[a];
      #1;
      n_chk++; if ({PSELx, PREADY, PSLVERR, PRDATA} !== {4'b0000, 1'b1, 1'b1, 32'h0}) begin n_fail++;
        $display("FAIL unmap_setup_%h: psel=%b rdy=%b err=%b rdata=%h exp 0000/1/1/0", addrs[a], PSELx, PREADY, PSLVERR, PRDATA); end
      tick;
      PENABLE = 1'b1;
      #1;
      n_chk++; if ({PSELx, PREADY, PSLVERR, PRDATA} !== {4'b0000, 1'b1, 1'b1, 32'h0}) begin n_fail++;
        $display("FAIL unmap_access_%h: psel=%b rdy=%b err=%b rdata=%h exp 0000/1/1/0", addrs[a], PSELx, PREADY, PSLVERR, PRDATA); end
      tick;
      PSEL = 1'b0; PENABLE = 1'b0;
      #1;
      n_chk++; if ({PREADY, PSLVERR, PRDATA} !== {1'b1, 1'b0, 32'h0}) begin n_fail++;
        $display("FAIL unmap_idle_%h: rdy=%b err=%b rdata=%h exp 1/0/0", addrs[a], PREADY, PSLVERR, PRDATA); end
      tick;
    end
  endtask

  task automatic test_pclken;
    PCLKEN = 1'b0;
    PREADYx[3] = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h300;
    #1;
    n_chk++; if (PSELx !== 4'b1000) begin n_fail++;
      $display("FAIL pce_setup_psel: got %b exp 1000", PSELx); end
    pclk_cycle;
    PENABLE = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_chk++; if ({PSELx, PREADY, PSLVERR} !== {4'b1000, 1'b0, 1'b0}) begin n_fail++;
        $display("FAIL pce_wait%0d: psel=%b rdy=%b err=%b exp 1000/0/0", k, PSELx, PREADY, PSLVERR); end
      pclk_cycle;
    end
    for (int k = 0; k < 10; k++) tick;
    #1;
    n_chk++; if ({PREADY, PSLVERR, TMO_FLAG} !== {1'b0, 1'b0, 1'b0}) begin n_fail++;
      $display("FAIL pce_frozen: rdy=%b err=%b flag=%b exp 0/0/0", PREADY, PSLVERR, TMO_FLAG); end
    PREADYx[3] = 1'b1;
    #1;
    n_chk++; if ({PREADY, PSLVERR, PRDATA} !== {1'b1, 1'b0, 32'hA5A5_0003}) begin n_fail++;
      $display("FAIL pce_done: rdy=%b err=%b rdata=%h exp 1/0/a5a50003", PREADY, PSLVERR, PRDATA); end
    pclk_cycle;
    PSEL = 1'b0; PENABLE = 1'b0;
    #1;
    n_chk++; if ({PSELx, PREADY, PSLVERR, TMO_FLAG} !== {4'b0000, 1'b1, 1'b0, 1'b0}) begin n_fail++;
      $display("FAIL pce_idle: psel=%b rdy=%b err=%b flag=%b exp 0000/1/0/0", PSELx, PREADY, PSLVERR, TMO_FLAG); end
    PCLKEN = 1'b1;
    tick;
  endtask

  task automatic test_back_to_back;
    PREADYx[0] = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h0;
    tick;
    PENABLE = 1'b1;
    for (int k = 0; k < 4; k++) tick;
    #1;
    n_chk++; if ({PSELx, PSLVERR} !== {4'b0000, 1'b1}) begin n_fail++;
      $display("FAIL b2b_tmo: psel=%b err=%b exp 0000/1", PSELx, PSLVERR); end
    tick;
    PENABLE = 1'b0; PADDR = 32'h200;
    #1;
    n_chk++; if (PSELx !== 4'b0100) begin n_fail++;
      $display("FAIL b2b_setup2: psel=%b exp 0100", PSELx); end
    tick;
    PENABLE = 1'b1;
    #1;
    n_chk++; if ({PREADY, PSLVERR, PRDATA} !== {1'b1, 1'b0, 32'hA5A5_0002}) begin n_fail++;
      $display("FAIL b2b_access2: rdy=%b err=%b rdata=%h exp 1/0/a5a50002", PREADY, PSLVERR, PRDATA); end
    tick;
    PENABLE = 1'b0; PADDR = 32'h100; PSLVERRx[1] = 1'b1;
    #1;
    n_chk++; if (PSELx !== 4'b0010) begin n_fail++;
      $display("FAIL b2b_setup1: psel=%b exp 0010", PSELx); end
    tick;
    PENABLE = 1'b1;
    #1;
    n_chk++; if ({PREADY, PSLVERR, PRDATA} !== {1'b1, 1'b1, 32'hA5A5_0001}) begin n_fail++;
      $display("FAIL b2b_access1: rdy=%b err=%b rdata=%h exp 1/1/a5a50001", PREADY, PSLVERR, PRDATA); end
    tick;
    PSEL = 1'b0; PENABLE = 1'b0; PSLVERRx[1] = 1'b0; PREADYx[0] = 1'b1;
    TMO_CLR = 1'b1;
    tick;
    TMO_CLR = 1'b0;
  endtask

  task automatic test_reset_mid;
    PREADYx[0] = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h0;
    tick;
    PENABLE = 1'b1;
    tick;
    tick;
    #1;
    HRESETn = 1'b0;
    #1;
    n_chk++; if ({PREADY, PSLVERR} !== {1'b1, 1'b0}) begin n_fail++;
      $display("FAIL rstmid_async: rdy=%b err=%b exp 1/0", PREADY, PSLVERR); end
    PSEL = 1'b0; PENABLE = 1'b0;
    #1;
    n_chk++; if ({PSELx, PREADY, PSLVERR, PRDATA, TMO_FLAG, TMO_ADDR} !== {4'b0000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0}) begin n_fail++;
      $display("FAIL rstmid_values: psel=%b rdy=%b err=%b rdata=%h flag=%b addr=%h exp all reset", PSELx, PREADY, PSLVERR, PRDATA, TMO_FLAG, TMO_ADDR); end
    tick;
    tick;
    HRESETn = 1'b1;
    PREADYx[0] = 1'b1;
    for (int k = 0; k < 3; k++) tick;
    test_read_slot2();
    #1;
    n_chk++; if (TMO_FLAG !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_flag: flag=%b exp 0", TMO_FLAG); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, exp completion before 100000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_slot2();
    tick;
    test_wait_slot1();
    tick;
    test_timeout();
    test_unmapped();
    test_pclken();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
